// File: rtl/uart_mem_pkg.sv
// Shared opcodes, tile geometry and parser states for the UART memory responder.
package uart_mem_pkg;

   localparam logic [7:0] OP_READ  = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_END   = 8'h02;
   localparam logic [7:0] RESP_HDR = 8'h01;

   localparam int TILE_BYTES = 36;
   localparam int TILE_BITS  = 288;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      WDATA,
      RD_MEM,
      TX_HDR,
      TX_DATA,
      TX_GAP
   } state_t;

endpackage

// File: rtl/smplfifo.sv
// Generic show-ahead FIFO; pop_data is valid whenever empty is low.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of two.
module smplfifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         empty,
   output logic         full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [0:DEPTH-1];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_mem_responder_tile_ram.sv
// Single-port tile RAM, one registered read cycle; contents survive reset.
module tile_ram #(
   parameter int ADDR_W    = 8,
   parameter int W         = 288,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/uart_mem_responder.sv
// UART-side memory host: parses READ/WRITE/END packets and answers READs with a header plus 36 tile bytes.
// Header strobe comes 3 cycles after the last address byte; each tx byte waits for tx_busy low, then a 1-cycle gap.
// UART_MEM_RESPONDER_RX_FIFO_EN adds an 8-deep rx FIFO so bytes arriving while busy are kept instead of dropped.
module uart_mem_responder #(
   parameter int ADDR_W     = 8,
   parameter int TILE_BYTES = 36,
   parameter     INIT_FILE  = ""
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       tx_busy,
   output logic       tx_en,
   output logic [7:0] tx_data,
   output logic       prog_done,
   output logic       err
);

   import uart_mem_pkg::*;

   state_t                state, state_nxt;
   logic [7:0]            op;
   logic [7:0]            addr_hi;
   logic [ADDR_W-1:0]     addr;
   logic [5:0]            cnt;
   logic                  wr_pend;
   logic [TILE_BITS-1:0]  asm_reg;
   logic [TILE_BITS-1:0]  sh_reg;
   logic [TILE_BITS-1:0]  ram_rdata;
   logic                  accept;
   logic                  in_vld;
   logic [7:0]            in_byte;
   logic                  drop;
   logic                  ram_we, ram_re, fire, end_op, bad_op;

   // The write-commit cycle is kept in WDATA with wr_pend set, so it refuses input too.
   assign accept = (state inside {IDLE, ADDR_HI, ADDR_LO, WDATA}) && !wr_pend;

`ifdef UART_MEM_RESPONDER_RX_FIFO_EN
   logic fifo_empty, fifo_full;

   smplfifo #(.W(8), .DEPTH(8)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (in_vld),
      .pop_data  (in_byte),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign in_vld = accept && !fifo_empty;
   assign drop   = rx_valid && fifo_full;
`else
   assign in_vld  = rx_valid && accept;
   assign in_byte = rx_data;
   assign drop    = rx_valid && !accept;
`endif

   tile_ram #(.ADDR_W(ADDR_W), .W(TILE_BITS), .INIT_FILE(INIT_FILE)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr),
      .wdata (asm_reg),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      fire      = 1'b0;
      end_op    = 1'b0;
      bad_op    = 1'b0;
      case (state)
         IDLE: begin
            if (in_vld) begin
               if (in_byte == OP_READ || in_byte == OP_WRITE) state_nxt = ADDR_HI;
               else if (in_byte == OP_END)                   end_op    = 1'b1;
               else                                          bad_op    = 1'b1;
            end
         end
         ADDR_HI: if (in_vld) state_nxt = ADDR_LO;
         ADDR_LO: if (in_vld) state_nxt = (op == OP_READ) ? RD_MEM : WDATA;
         WDATA: begin
            if (wr_pend) begin
               ram_we    = 1'b1;
               state_nxt = IDLE;
            end
         end
         RD_MEM: begin
            ram_re    = 1'b1;
            state_nxt = TX_HDR;
         end
         TX_HDR, TX_DATA: begin
            if (!tx_busy) begin
               fire      = 1'b1;
               state_nxt = TX_GAP;
            end
         end
         TX_GAP:  state_nxt = (cnt == 6'(TILE_BYTES)) ? IDLE : TX_DATA;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_en     <= 1'b0;
         tx_data   <= '0;
         prog_done <= 1'b0;
         err       <= 1'b0;
         op        <= '0;
         addr_hi   <= '0;
         addr      <= '0;
         cnt       <= '0;
         wr_pend   <= 1'b0;
         asm_reg   <= '0;
         sh_reg    <= '0;
      end else begin
         tx_en     <= fire;
         prog_done <= end_op;
         if (bad_op || drop) err <= 1'b1;
         if (state == IDLE && in_vld)    op      <= in_byte;
         if (state == ADDR_HI && in_vld) addr_hi <= in_byte;
         if (state == ADDR_LO && in_vld) begin
            addr <= ADDR_W'({addr_hi, in_byte});
            cnt  <= '0;
         end
         if (state == WDATA) begin
            if (wr_pend) begin
               wr_pend <= 1'b0;
            end else if (in_vld) begin
               asm_reg <= {asm_reg[TILE_BITS-9:0], in_byte};
               cnt     <= cnt + 1'b1;
               if (cnt == 6'(TILE_BYTES - 1)) wr_pend <= 1'b1;
            end
         end
         // RAM output is stable from TX_HDR onward since only RD_MEM issues a read.
         if (fire) begin
            if (state == TX_HDR) begin
               tx_data <= RESP_HDR;
               sh_reg  <= ram_rdata;
            end else begin
               tx_data <= sh_reg[TILE_BITS-1 -: 8];
               sh_reg  <= {sh_reg[TILE_BITS-9:0], 8'h00};
               cnt     <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed bench for uart_mem_responder: packet parsing, read responses, tx handshake, errors and reset.
module tb_uart_mem_responder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_busy = 1'b0;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       prog_done;
   logic       err;

   uart_mem_responder #(.ADDR_W(8), .TILE_BYTES(36), .INIT_FILE("")) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_busy   (tx_busy),
      .tx_en     (tx_en),
      .tx_data   (tx_data),
      .prog_done (prog_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         last_rx_cyc = 0;
   int         consec = 0;
   logic       prev_tx = 1'b0;
   logic [7:0] tx_q[$];
   int         tx_cyc_q[$];
   int         pd_q[$];
   logic [7:0] exp_tile [0:35];   // expected contents of tile address 5

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_en === 1'b1) begin
         tx_q.push_back(tx_data);
         tx_cyc_q.push_back(cyc);
         if (prev_tx === 1'b1) consec++;
      end
      prev_tx = tx_en;
      if (prog_done === 1'b1) pd_q.push_back(cyc);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_q();
      tx_q.delete();
      tx_cyc_q.delete();
      pd_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid    = 1'b1;
      rx_data     = b;
      last_rx_cyc = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_read(input logic [15:0] a);
      send_byte(8'h00);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic send_write(input logic [15:0] a, input logic [7:0] base, input int n);
      send_byte(8'h01);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      for (int i = 0; i < n; i++) send_byte(8'(base + i));
   endtask

   task automatic wait_tx(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (tx_en !== 1'b0)      begin fails++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
      tests++; if (tx_data !== 8'h00)   begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      tests++; if (prog_done !== 1'b0)  begin fails++; $display("FAIL reset_prog_done: got %b want 0", prog_done); end
      tests++; if (err !== 1'b0)        begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (err !== 1'b0 || tx_en !== 1'b0) begin
         fails++; $display("FAIL post_reset_idle: got err=%b tx_en=%b want 0 0", err, tx_en);
      end
   endtask

   task automatic test_write_read();
      bit ok;
      int rd_cyc;
      clear_q();
      send_write(16'h0005, 8'h00, 36);
      for (int i = 0; i < 36; i++) exp_tile[i] = 8'(i);
      repeat (3) @(negedge clk);
      send_read(16'h0005);
      rd_cyc = last_rx_cyc;
      wait_tx(37, 300, ok);
      repeat (10) @(negedge clk);
      tests++; if (!ok || tx_q.size() != 37) begin
         fails++; $display("FAIL wr_rd_count: got %0d strobes want 37", tx_q.size());
      end
      if (ok) begin
         tests++; if (tx_cyc_q[0] - rd_cyc < 2 || tx_cyc_q[0] - rd_cyc > 6) begin
            fails++; $display("FAIL wr_rd_latency: got %0d cycles want 2..6", tx_cyc_q[0] - rd_cyc);
         end
         tests++; if (tx_q[0] !== 8'h01) begin fails++; $display("FAIL wr_rd_hdr: got %h want 01", tx_q[0]); end
         for (int i = 0; i < 36; i++) begin
            tests++; if (tx_q[i+1] !== exp_tile[i]) begin
               fails++; $display("FAIL wr_rd_byte%0d: got %h want %h", i, tx_q[i+1], exp_tile[i]);
            end
         end
      end
      tests++; if (err !== 1'b0)  begin fails++; $display("FAIL wr_rd_err: got %b want 0", err); end
      tests++; if (consec != 0)   begin fails++; $display("FAIL wr_rd_consec: got %0d back-to-back strobes want 0", consec); end
   endtask

   task automatic test_prog_end();
      int c;
      clear_q();
      send_byte(8'h02);
      c = last_rx_cyc;
      repeat (6) @(negedge clk);
      tests++; if (pd_q.size() != 1) begin fails++; $display("FAIL end_pulse_count: got %0d want 1", pd_q.size()); end
      if (pd_q.size() >= 1) begin
         tests++; if (pd_q[0] != c + 1) begin fails++; $display("FAIL end_pulse_cycle: got %0d want %0d", pd_q[0], c + 1); end
      end
      tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL end_no_tx: got %0d strobes want 0", tx_q.size()); end
   endtask

   task automatic test_bad_opcode();
      bit ok;
      clear_q();
      send_byte(8'h7F);
      repeat (2) @(negedge clk);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_op_err: got %b want 1", err); end
      send_read(16'h0005);
      wait_tx(37, 300, ok);
      tests++; if (!ok) begin fails++; $display("FAIL bad_op_read: got %0d strobes want 37", tx_q.size()); end
      if (ok) begin
         for (int i = 0; i < 36; i++) begin
            tests++; if (tx_q[i+1] !== exp_tile[i]) begin
               fails++; $display("FAIL bad_op_byte%0d: got %h want %h", i, tx_q[i+1], exp_tile[i]);
            end
         end
      end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_op_sticky: got %b want 1", err); end
   endtask

   task automatic test_alias();
      bit ok;
      clear_q();
      send_write(16'h0105, 8'h50, 36);
      for (int i = 0; i < 36; i++) exp_tile[i] = 8'(8'h50 + i);
      repeat (3) @(negedge clk);
      send_read(16'h0005);
      wait_tx(37, 300, ok);
      tests++; if (!ok) begin fails++; $display("FAIL alias_read: got %0d strobes want 37", tx_q.size()); end
      if (ok) begin
         tests++; if (tx_q[0] !== 8'h01) begin fails++; $display("FAIL alias_hdr: got %h want 01", tx_q[0]); end
         for (int i = 0; i < 36; i++) begin
            tests++; if (tx_q[i+1] !== exp_tile[i]) begin
               fails++; $display("FAIL alias_byte%0d: got %h want %h", i, tx_q[i+1], exp_tile[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      bit ok;
      clear_q();
      send_write(16'h0005, 8'hA0, 20);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL midrst_tx_en%0d: got %b want 0", i, tx_en); end
      end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b want 0", err); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      send_read(16'h0005);
      wait_tx(37, 300, ok);
      tests++; if (!ok) begin fails++; $display("FAIL midrst_read: got %0d strobes want 37", tx_q.size()); end
      if (ok) begin
         for (int i = 0; i < 36; i++) begin
            tests++; if (tx_q[i+1] !== exp_tile[i]) begin
               fails++; $display("FAIL midrst_byte%0d: got %h want %h", i, tx_q[i+1], exp_tile[i]);
            end
         end
      end
   endtask

   task automatic test_tx_busy();
      bit ok;
      int rel;
      clear_q();
      consec = 0;
      send_read(16'h0005);
      wait_tx(1, 50, ok);
      tests++; if (!ok) begin fails++; $display("FAIL busy_hdr: got %0d strobes want 1", tx_q.size()); end
      tx_busy = 1'b1;
      repeat (100) @(negedge clk);
      tests++; if (tx_q.size() != 1) begin fails++; $display("FAIL busy_hold: got %0d strobes want 1", tx_q.size()); end
      rel = cyc;
      tx_busy = 1'b0;
      wait_tx(37, 300, ok);
      tests++; if (!ok) begin fails++; $display("FAIL busy_resume: got %0d strobes want 37", tx_q.size()); end
      if (ok) begin
         tests++; if (tx_cyc_q[1] < rel + 1) begin
            fails++; $display("FAIL busy_resume_cycle: got %0d want >= %0d", tx_cyc_q[1], rel + 1);
         end
         for (int i = 0; i < 36; i++) begin
            tests++; if (tx_q[i+1] !== exp_tile[i]) begin
               fails++; $display("FAIL busy_byte%0d: got %h want %h", i, tx_q[i+1], exp_tile[i]);
            end
         end
      end
      tests++; if (consec != 0) begin fails++; $display("FAIL busy_consec: got %0d want 0", consec); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL busy_err: got %b want 0", err); end
   endtask

   task automatic test_overrun();
      bit ok;
      clear_q();
      send_read(16'h0005);
      wait_tx(5, 100, ok);
      send_byte(8'h00);
      wait_tx(37, 300, ok);
      repeat (10) @(negedge clk);
      tests++; if (!ok || tx_q.size() != 37) begin
         fails++; $display("FAIL ovr_count: got %0d strobes want 37", tx_q.size());
      end
      if (ok) begin
         for (int i = 0; i < 36; i++) begin
            tests++; if (tx_q[i+1] !== exp_tile[i]) begin
               fails++; $display("FAIL ovr_byte%0d: got %h want %h", i, tx_q[i+1], exp_tile[i]);
            end
         end
      end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL ovr_err: got %b want 1", err); end
      send_byte(8'h02);
      repeat (3) @(negedge clk);
      tests++; if (pd_q.size() != 1) begin fails++; $display("FAIL ovr_then_end: got %0d pulses want 1", pd_q.size()); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_prog_end();
      test_bad_opcode();
      test_alias();
      test_reset_mid_write();
      test_tx_busy();
      test_overrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
